// File: rtl/pc_controller.sv
// pc_controller: fetch-side program-counter sequencer.
// Loads the reset vector from instruction memory, then steps the PC. It
// redirects the PC on exm-stage branches and on two-beat popped return
// addresses, and takes interrupts by pushing the current PC and jumping to
// INT_VECTOR.
module pc_controller #(
    parameter logic [31:0] RESET_VECTOR_ADDR = 32'd0,
    parameter logic [31:0] INT_VECTOR        = 32'd2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_decision,
    input  logic [31:0] i_pc_new,
    input  logic        i_pop_valid,
    input  logic [15:0] i_pop_data,
    input  logic        i_interrupt,
    input  logic [15:0] i_imem_data,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus1,
    output logic        o_flush,
    output logic        o_int_ack,
    output logic [31:0] o_push_pc,
    output logic        o_ready
);

    typedef enum logic [1:0] {
        RST_HI,
        RST_LO,
        RUN,
        POP_LO
    } state_t;

    state_t      state;
    logic [15:0] hi_reg;
    logic        int_pending;

    logic take_pop;
    logic take_branch;
    logic take_int;

    // Priority decode of the RUN-state redirect sources: pop, branch, interrupt
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        take_pop    = 1'b0;
        take_branch = 1'b0;
        take_int    = 1'b0;
        if (state == RUN) begin
            take_pop    = i_pop_valid;
            take_branch = !i_pop_valid && i_branch_decision;
            take_int    = !i_pop_valid && !i_branch_decision && (int_pending || i_interrupt);
        end
    end

    // Instruction-memory address: reset-vector words during boot, PC afterwards
    always_comb begin
        o_imem_addr = o_pc;
        case (state)
            RST_HI:  o_imem_addr = RESET_VECTOR_ADDR;
            RST_LO:  o_imem_addr = RESET_VECTOR_ADDR + 32'd1;
            default: o_imem_addr = o_pc;
        endcase
    end

    assign o_pc_plus1 = o_pc + 32'd1;

    // Fetched word is unusable while booting, waiting on a pop, or redirecting
    assign o_flush = (state != RUN) || take_pop || take_branch || take_int;

    // Sequencer state, PC and registered interrupt outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= RST_HI;
            o_pc        <= 32'd0;
            hi_reg      <= 16'd0;
            int_pending <= 1'b0;
            o_int_ack   <= 1'b0;
            o_push_pc   <= 32'd0;
            o_ready     <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every read in this block sees pre-edge values.
            o_int_ack <= 1'b0;
            // A request that cannot be taken this edge is remembered; repeats collapse.
            if (i_interrupt && !take_int) begin
                int_pending <= 1'b1;
            end
            case (state)
                RST_HI: begin
                    hi_reg <= i_imem_data;
                    state  <= RST_LO;
                end
                RST_LO: begin
                    o_pc    <= {hi_reg, i_imem_data};
                    o_ready <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (take_pop) begin
                        hi_reg <= i_pop_data;
                        state  <= POP_LO;
                    end else if (take_branch) begin
                        o_pc <= i_pc_new;
                    end else if (take_int) begin
                        o_push_pc   <= o_pc;
                        o_int_ack   <= 1'b1;
                        o_pc        <= INT_VECTOR;
                        int_pending <= 1'b0;
                    end else if (!i_stall) begin
                        o_pc <= o_pc_plus1;
                    end
                end
                POP_LO: begin
                    if (i_pop_valid) begin
                        o_pc  <= {hi_reg, i_pop_data};
                        state <= RUN;
                    end
                end
                default: state <= RST_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: directed scenarios followed by
// randomized traffic, both compared against a cycle-level reference model.
module tb_pc_controller;

    localparam int P_HI  = 0;  // fetching reset-vector high word
    localparam int P_LO  = 1;  // fetching reset-vector low word
    localparam int P_RUN = 2;  // normal sequencing
    localparam int P_POP = 3;  // waiting for low half of a popped PC

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_branch_decision = 1'b0;
    logic [31:0] i_pc_new = 32'd0;
    logic        i_pop_valid = 1'b0;
    logic [15:0] i_pop_data = 16'd0;
    logic        i_interrupt = 1'b0;
    logic [15:0] i_imem_data;
    logic [31:0] o_imem_addr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus1;
    logic        o_flush;
    logic        o_int_ack;
    logic [31:0] o_push_pc;
    logic        o_ready;

    logic [15:0] rv_hi = 16'h0000;
    logic [15:0] rv_lo = 16'h0040;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_push;
    logic [15:0] m_hi;
    logic        m_pend;
    logic        m_ack;
    logic        m_ready;

    pc_controller dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_stall           (i_stall),
        .i_branch_decision (i_branch_decision),
        .i_pc_new          (i_pc_new),
        .i_pop_valid       (i_pop_valid),
        .i_pop_data        (i_pop_data),
        .i_interrupt       (i_interrupt),
        .i_imem_data       (i_imem_data),
        .o_imem_addr       (o_imem_addr),
        .o_pc              (o_pc),
        .o_pc_plus1        (o_pc_plus1),
        .o_flush           (o_flush),
        .o_int_ack         (o_int_ack),
        .o_push_pc         (o_push_pc),
        .o_ready           (o_ready)
    );

    always #5 i_clk = ~i_clk;

    // Instruction memory: reset vector at 0/1, address-derived filler elsewhere
    assign i_imem_data = (o_imem_addr == 32'd0) ? rv_hi :
                         (o_imem_addr == 32'd1) ? rv_lo :
                         (o_imem_addr[15:0] ^ 16'hA5A5);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic stall, input logic br, input logic [31:0] pc_new,
                          input logic pop, input logic [15:0] pop_data, input logic intr);
        i_stall           = stall;
        i_branch_decision = br;
        i_pc_new          = pc_new;
        i_pop_valid       = pop;
        i_pop_data        = pop_data;
        i_interrupt       = intr;
    endtask

    task automatic model_reset();
        m_phase = P_HI;
        m_pc    = 32'd0;
        m_hi    = 16'd0;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
        m_push  = 32'd0;
        m_ready = 1'b0;
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // model by the redirect rules, then check registered outputs after it.
    task automatic cycle();
        logic [31:0] exp_addr;
        logic        exp_flush;
        logic        fire_pop;
        logic        fire_br;
        logic        fire_int;
        @(negedge i_clk);
        fire_pop  = (m_phase == P_RUN) && i_pop_valid;
        fire_br   = (m_phase == P_RUN) && !i_pop_valid && i_branch_decision;
        fire_int  = (m_phase == P_RUN) && !fire_pop && !fire_br && (m_pend || i_interrupt);
        exp_addr  = (m_phase == P_HI) ? 32'd0 : (m_phase == P_LO) ? 32'd1 : m_pc;
        exp_flush = (m_phase != P_RUN) || fire_pop || fire_br || fire_int;
        check("imem_addr", o_imem_addr, exp_addr);
        check("flush", {31'd0, o_flush}, {31'd0, exp_flush});
        check("pc_plus1", o_pc_plus1, m_pc + 32'd1);

        m_ack = 1'b0;
        if (i_interrupt && !fire_int) m_pend = 1'b1;
        case (m_phase)
            P_HI: begin
                m_hi    = rv_hi;
                m_phase = P_LO;
            end
            P_LO: begin
                m_pc    = {m_hi, rv_lo};
                m_ready = 1'b1;
                m_phase = P_RUN;
            end
            P_POP: begin
                if (i_pop_valid) begin
                    m_pc    = {m_hi, i_pop_data};
                    m_phase = P_RUN;
                end
            end
            default: begin
                if (fire_pop) begin
                    m_hi    = i_pop_data;
                    m_phase = P_POP;
                end else if (fire_br) begin
                    m_pc = i_pc_new;
                end else if (fire_int) begin
                    m_push = m_pc;
                    m_ack  = 1'b1;
                    m_pc   = 32'd2;
                    m_pend = 1'b0;
                end else if (!i_stall) begin
                    m_pc = m_pc + 32'd1;
                end
            end
        endcase

        @(posedge i_clk);
        #1;
        check("pc", o_pc, m_pc);
        check("ready", {31'd0, o_ready}, {31'd0, m_ready});
        check("int_ack", {31'd0, o_int_ack}, {31'd0, m_ack});
        check("push_pc", o_push_pc, m_push);
    endtask

    // Assert reset asynchronously between edges, check it took effect at
    // once, then release it just after a rising edge.
    task automatic do_reset();
        #1;
        i_reset = 1'b0;
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        #1;
        model_reset();
        check("rst_pc", o_pc, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_int_ack", {31'd0, o_int_ack}, 32'd0);
        check("rst_flush", {31'd0, o_flush}, 32'd1);
        check("rst_addr", o_imem_addr, 32'd0);
        check("rst_push_pc", o_push_pc, 32'd0);
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
    endtask

    initial begin
        model_reset();

        // Boot from reset vector 0x0000_0040
        do_reset();
        cycle();
        check("boot_not_ready_edge1", {31'd0, o_ready}, 32'd0);
        cycle();
        check("boot_pc", o_pc, 32'h40);
        check("boot_ready_edge2", {31'd0, o_ready}, 32'd1);
        cycle();
        check("first_inc", o_pc, 32'h41);

        // Branch overrides stall; stall alone holds
        set_in(1'b0, 1'b1, 32'h10, 1'b0, 16'd0, 1'b0);
        cycle();
        set_in(1'b1, 1'b1, 32'h200, 1'b0, 16'd0, 1'b0);
        cycle();
        check("stall_branch", o_pc, 32'h200);
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        cycle();
        cycle();
        check("stall_hold", o_pc, 32'h200);

        // Two-beat pop from 0x30
        set_in(1'b0, 1'b1, 32'h30, 1'b0, 16'd0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b1, 16'h0001, 1'b0);
        cycle();
        check("pop_hold_pc", o_pc, 32'h30);
        set_in(1'b0, 1'b0, 32'd0, 1'b1, 16'h2345, 1'b0);
        cycle();
        check("pop_pc", o_pc, 32'h0001_2345);

        // Interrupt at 0x55
        set_in(1'b0, 1'b1, 32'h55, 1'b0, 16'd0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b1);
        cycle();
        check("int_ack", {31'd0, o_int_ack}, 32'd1);
        check("int_push", o_push_pc, 32'h55);
        check("int_vec", o_pc, 32'h2);
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        cycle();
        check("int_ack_one_cycle", {31'd0, o_int_ack}, 32'd0);

        // Interrupt with simultaneous branch: branch first, interrupt next
        set_in(1'b0, 1'b1, 32'h80, 1'b0, 16'd0, 1'b1);
        cycle();
        check("br_int_pc", o_pc, 32'h80);
        check("br_int_no_ack", {31'd0, o_int_ack}, 32'd0);
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        cycle();
        check("br_int_ack", {31'd0, o_int_ack}, 32'd1);
        check("br_int_push", o_push_pc, 32'h80);

        // Interrupt arriving in POP_LO, taken on the first RUN edge
        set_in(1'b0, 1'b0, 32'd0, 1'b1, 16'hABCD, 1'b0);
        cycle();
        set_in(1'b1, 1'b1, 32'h999, 1'b0, 16'd0, 1'b1);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b1, 16'h1234, 1'b0);
        cycle();
        check("pop_int_pc", o_pc, 32'hABCD_1234);
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        cycle();
        check("pop_int_ack", {31'd0, o_int_ack}, 32'd1);
        check("pop_int_push", o_push_pc, 32'hABCD_1234);

        // Wrap from 0xFFFF_FFFF
        set_in(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        cycle();
        check("wrap", o_pc, 32'd0);

        // Reset while in POP_LO
        set_in(1'b0, 1'b0, 32'd0, 1'b1, 16'h1111, 1'b0);
        cycle();
        do_reset();

        // Randomized traffic with periodic resets and fresh reset vectors
        for (int it = 0; it < 900; it++) begin
            if (it % 150 == 0) begin
                rv_hi = 16'($urandom);
                rv_lo = 16'($urandom);
                do_reset();
            end
            i_stall           = ($urandom_range(0, 3) == 0);
            i_branch_decision = ($urandom_range(0, 7) == 0);
            i_pc_new          = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            i_pop_valid       = (m_phase == P_POP) ? ($urandom_range(0, 1) == 1)
                                                   : ($urandom_range(0, 9) == 0);
            i_pop_data        = 16'($urandom);
            i_interrupt       = (m_phase >= P_RUN) && ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
Name: pc_controller

Overview:
- Fetch-side program-counter sequencer.
- Consumes the redirect outputs of the execute-memory stage: branch decision with new PC, and popped-PC beats from data memory for RET/RTI.
- Drives the instruction-memory address, loads the reset vector from instruction memory, and takes interrupts.
- Sits between the hazard unit, the exm stage and the instruction memory / IF-ID buffer.

Parameters:
RESET_VECTOR_ADDR, 32'd0, instruction-memory address of the high word of the reset vector; low word is at +1
INT_VECTOR, 32'd2, PC loaded on interrupt entry

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  asynchronous, active-low reset
i_stall  input  1  hazard-unit hold; freezes PC
i_branch_decision  input  1  exm-stage branch taken this cycle
i_pc_new  input  32  exm-stage branch target; valid when i_branch_decision=1
i_pop_valid  input  1  one popped PC half is on i_pop_data; high half first, then low half
i_pop_data  input  16  popped PC half from data memory
i_interrupt  input  1  interrupt request, level or pulse
i_imem_data  input  16  instruction-memory read data, combinational in address
o_imem_addr  output  32  instruction-memory address
o_pc  output  32  current PC register
o_pc_plus1  output  32  o_pc+1, mod 2^32
o_flush  output  1  flush the IF/ID buffer
o_int_ack  output  1  one-cycle interrupt-taken pulse
o_push_pc  output  32  PC to be pushed by the exm stage; valid with o_int_ack
o_ready  output  1  reset-vector load complete

Behaviour:
- States: RST_HI, RST_LO, RUN, POP_LO.
- Reset (i_reset=0, asynchronous):
  - state=RST_HI, o_pc=0, hi_reg=0, int_pending=0.
  - o_int_ack=0, o_push_pc=0, o_ready=0.
  - o_flush=1 while in RST_HI or RST_LO.
  - Reset mid-operation aborts any pop, branch or interrupt; nothing is retained.
- RST_HI:
  - o_imem_addr=RESET_VECTOR_ADDR.
  - Edge: hi_reg<=i_imem_data, go to RST_LO.
- RST_LO:
  - o_imem_addr=RESET_VECTOR_ADDR+1.
  - Edge: o_pc<={hi_reg,i_imem_data}, o_ready<=1, go to RUN.
  - o_ready rises on the 2nd rising edge after reset release.
  - All inputs except i_imem_data are ignored during RST_*.
- RUN: o_imem_addr=o_pc. Per edge, first matching rule applies:
  1. i_pop_valid: hi_reg<=i_pop_data; go to POP_LO; PC held.
  2. i_branch_decision: o_pc<=i_pc_new; overrides i_stall.
  3. int_pending or i_interrupt: o_push_pc<=o_pc, o_int_ack<=1 for one cycle, o_pc<=INT_VECTOR, int_pending<=0.
  4. i_stall: PC held.
  5. Otherwise: o_pc<=o_pc_plus1; 32'hFFFF_FFFF wraps to 0.
- POP_LO:
  - PC held; i_branch_decision and i_stall ignored.
  - i_pop_valid: o_pc<={hi_reg,i_pop_data}, go to RUN.
  - No beat: remain in POP_LO indefinitely.
- o_flush (combinational):
  - 1 in RST_*.
  - 1 in POP_LO.
  - 1 in RUN when rule 1, 2 or 3 fires.
  - 0 otherwise.
- Interrupt latching:
  - int_pending<=1 when i_interrupt=1 and the request is not taken that cycle: state RST_* or POP_LO, or rule 1/2 fires.
  - A pending interrupt is taken at the first RUN edge where neither rule 1 nor rule 2 fires.
  - A stall does not delay it; rule 3 outranks rule 4.
  - Multiple requests while pending collapse to one.
- o_int_ack is registered: high for exactly the cycle after the entry edge.
- o_push_pc holds its value until the next interrupt entry.
- o_pc_plus1 is combinational from o_pc.

Test Plan:
- Reset, imem[0]=16'h0000, imem[1]=16'h0040 -> o_flush=1 two cycles; o_ready rises on edge 2; o_pc=32'h40; next unstalled edge o_pc=32'h41.
- RUN o_pc=32'h10, i_stall=1 with i_branch_decision=1, i_pc_new=32'h200 -> o_pc=32'h200 next edge; o_flush=1 during that cycle; stall otherwise holds o_pc.
- RUN o_pc=32'h30, i_pop_valid beats 16'h0001 then 16'h2345 on consecutive cycles -> o_pc=32'h0001_2345 after 2nd beat; o_flush=1 both cycles.
- i_interrupt pulsed at o_pc=32'h55, no stall -> o_int_ack=1 one cycle; o_push_pc=32'h55; o_pc=32'h2.
- i_interrupt pulsed in the same cycle as a branch to 32'h80 -> branch taken first; interrupt taken next edge with o_push_pc=32'h80. Repeat with the pulse arriving in POP_LO -> taken on the first RUN edge.
- o_pc=32'hFFFF_FFFF, increment -> o_pc=0. Drop i_reset in POP_LO -> state RST_HI, o_ready=0, o_int_ack=0 immediately.
